// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU sequencing controller and its register file.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_e;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_EXEC = 2'd1;
  localparam state_t ST_WB   = 2'd2;

  localparam logic [1:0] EXC_NONE   = 2'b00;
  localparam logic [1:0] EXC_CARRY  = 2'b01;
  localparam logic [1:0] EXC_BORROW = 2'b10;
  localparam logic [1:0] EXC_DIV0   = 2'b11;

endpackage

// File: rtl/alu_seq_regfile.sv
// NREG x DATA_W register file: two operand read ports, one debug read port, one write port.
// Entry 0 is hardwired to zero.
module alu_seq_regfile
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREG   = 16,
  parameter int AW     = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW-1:0]     raddr1,
  input  logic [AW-1:0]     raddr2,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic [DATA_W-1:0] dbg_data,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] mem [NREG];

  // NOTE: this memory is cleared by the async reset, so it maps to flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we && waddr != '0) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata1   = (raddr1   == '0) ? '0 : mem[raddr1];
  assign rdata2   = (raddr2   == '0) ? '0 : mem[raddr2];
  assign dbg_data = (dbg_addr == '0) ? '0 : mem[dbg_addr];

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequencing controller for the shared 16-bit add/sub/mul/div datapath: accepts one
// instruction at a time, drives the datapath, holds divides for DIV_LAT cycles, writes back.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int NREG    = 16,
  parameter int DIV_LAT = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic [1:0]               instr_op,
  input  logic [$clog2(NREG)-1:0]  instr_rd,
  input  logic [$clog2(NREG)-1:0]  instr_rs1,
  input  logic [$clog2(NREG)-1:0]  instr_rs2,
  input  logic                     instr_cin,
  output logic [1:0]               alu_f0,
  output logic [DATA_W-1:0]        alu_a,
  output logic [DATA_W-1:0]        alu_b,
  output logic                     alu_cin,
  output logic                     alu_bin,
  input  logic [DATA_W-1:0]        alu_result,
  input  logic                     alu_flag,
  input  logic [$clog2(NREG)-1:0]  dbg_addr,
  output logic [DATA_W-1:0]        dbg_data,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(NREG)-1:0]  done_rd,
  output logic                     exc,
  output logic [1:0]               exc_code
);

  localparam int AW = $clog2(NREG);
  localparam int CW = $clog2(DIV_LAT + 1);

  state_t            state;
  op_e               op;
  logic [AW-1:0]     rd;
  logic              cin;
  logic [DATA_W-1:0] opa, opb, res;
  logic [1:0]        exc_r;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] rdata1, rdata2;
  logic              in_exec;

  alu_seq_regfile #(.DATA_W(DATA_W), .NREG(NREG), .AW(AW)) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .raddr1   (instr_rs1),
    .raddr2   (instr_rs2),
    .dbg_addr (dbg_addr),
    .rdata1   (rdata1),
    .rdata2   (rdata2),
    .dbg_data (dbg_data),
    .we       (done),
    .waddr    (rd),
    .wdata    (res)
  );

  // NOTE: all state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      op    <= OP_ADD;
      rd    <= '0;
      cin   <= 1'b0;
      opa   <= '0;
      opb   <= '0;
      res   <= '0;
      exc_r <= EXC_NONE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (instr_valid) begin
            op    <= op_e'(instr_op);
            rd    <= instr_rd;
            cin   <= instr_cin;
            opa   <= rdata1;
            opb   <= rdata2;
            cnt   <= CW'(DIV_LAT);
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (op)
            OP_ADD: begin
              res   <= alu_result;
              exc_r <= alu_flag ? EXC_CARRY : EXC_NONE;
              state <= ST_WB;
            end
            OP_SUB: begin
              res   <= alu_result;
              exc_r <= alu_flag ? EXC_BORROW : EXC_NONE;
              state <= ST_WB;
            end
            OP_MUL: begin
              res   <= alu_result;
              exc_r <= EXC_NONE;
              state <= ST_WB;
            end
            default: begin
              // Divide by zero never waits on the divider; its result is defined here.
              if (opb == '0) begin
                res   <= '1;
                exc_r <= EXC_DIV0;
                state <= ST_WB;
              end else if (cnt == CW'(1)) begin
                res   <= alu_result;
                exc_r <= EXC_NONE;
                state <= ST_WB;
              end else begin
                cnt <= cnt - CW'(1);
              end
            end
          endcase
        end
        ST_WB:   state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_exec     = (state == ST_EXEC);
  assign instr_ready = (state == ST_IDLE);
  assign busy        = !instr_ready;
  assign done        = (state == ST_WB);
  assign done_rd     = done ? rd : '0;
  assign exc_code    = done ? exc_r : EXC_NONE;
  assign exc         = done && (exc_r != EXC_NONE);

  assign alu_f0  = in_exec ? op  : 2'b00;
  assign alu_a   = in_exec ? opa : '0;
  assign alu_b   = in_exec ? opb : '0;
  assign alu_cin = in_exec && (op == OP_ADD) && cin;
  assign alu_bin = in_exec && (op == OP_SUB) && cin;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: directed corner cases plus random instructions,
// checked against a register-array reference model; includes a behavioural datapath.
module tb_alu_seq_ctrl;

  localparam int DATA_W  = 16;
  localparam int NREG    = 16;
  localparam int DIV_LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [1:0]  instr_op = '0;
  logic [3:0]  instr_rd = '0, instr_rs1 = '0, instr_rs2 = '0;
  logic        instr_cin = 1'b0;
  logic [1:0]  alu_f0;
  logic [15:0] alu_a, alu_b;
  logic        alu_cin, alu_bin;
  logic [15:0] alu_result;
  logic        alu_flag;
  logic [3:0]  dbg_addr = '0;
  logic [15:0] dbg_data;
  logic        busy, done, exc;
  logic [3:0]  done_rd;
  logic [1:0]  exc_code;

  int n_checks = 0;
  int n_err    = 0;
  logic [15:0] m [16];

  always #5 clk = ~clk;

  alu_seq_ctrl #(.DATA_W(DATA_W), .NREG(NREG), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
    .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2), .instr_cin(instr_cin),
    .alu_f0(alu_f0), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_bin(alu_bin),
    .alu_result(alu_result), .alu_flag(alu_flag),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .busy(busy), .done(done), .done_rd(done_rd), .exc(exc), .exc_code(exc_code)
  );

  // Behavioural datapath; the divider only produces a valid quotient once it has been held DIV_LAT cycles.
  int          div_age = 0;
  logic [16:0] dp_wide;
  logic [31:0] dp_prod;

  always_ff @(posedge clk) div_age <= (alu_f0 == 2'b11) ? div_age + 1 : 0;

  always_comb begin
    dp_wide    = '0;
    dp_prod    = '0;
    alu_result = '0;
    alu_flag   = 1'b0;
    case (alu_f0)
      2'b00: begin
        dp_wide    = {1'b0, alu_a} + {1'b0, alu_b} + {16'd0, alu_cin};
        alu_result = dp_wide[15:0];
        alu_flag   = dp_wide[16];
      end
      2'b01: begin
        dp_wide    = {1'b0, alu_a} - {1'b0, alu_b} - {16'd0, alu_bin};
        alu_result = dp_wide[15:0];
        alu_flag   = dp_wide[16];
      end
      2'b10: begin
        dp_prod    = {16'd0, alu_a} * {16'd0, alu_b};
        alu_result = dp_prod[15:0];
      end
      default: begin
        if (alu_b == 16'd0)               alu_result = 16'h1234;
        else if (div_age >= DIV_LAT - 1)  alu_result = alu_a / alu_b;
        else                              alu_result = 16'hDEAD;
      end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < 16; i++) m[i] = 16'd0;
  endtask

  task automatic sweep_regs(input string tag);
    for (int i = 0; i < 16; i++) begin
      dbg_addr = 4'(i);
      #1;
      check($sformatf("%s_r%0d", tag, i), dbg_data, m[i]);
    end
  endtask

  // Issue one instruction, check EXEC outputs, completion timing, exception and write-back.
  task automatic run_instr(input logic [1:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                           input logic [3:0] rs2, input logic cn, input bit skip_wait);
    logic [15:0] ea, eb, eres;
    logic [16:0] w;
    logic [31:0] p;
    logic [1:0]  eec;
    int          ecyc, c, f0_cnt;
    bit          got;
    if (!skip_wait) @(negedge clk);
    check("ready_idle", instr_ready, 1);
    check("alu_idle_zero", alu_a | alu_b | {14'd0, alu_f0} | {15'd0, alu_cin | alu_bin}, 0);
    ea = m[rs1];
    eb = m[rs2];
    eec = 2'b00;
    case (op)
      2'b00: begin
        w = 17'(ea) + 17'(eb) + 17'(cn);
        eres = w[15:0];
        if (w[16]) eec = 2'b01;
      end
      2'b01: begin
        eres = ea - eb - 16'(cn);
        if (32'(ea) < 32'(eb) + 32'(cn)) eec = 2'b10;
      end
      2'b10: begin
        p = 32'(ea) * 32'(eb);
        eres = p[15:0];
      end
      default: begin
        if (eb == 0) begin eres = 16'hFFFF; eec = 2'b11; end
        else eres = ea / eb;
      end
    endcase
    ecyc = (op == 2'b11 && eb != 0) ? 1 + DIV_LAT : 2;
    instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2; instr_cin = cn;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    // While busy, keep offering unrelated junk; it must be ignored.
    instr_valid = 1'($urandom_range(0, 1));
    instr_op = 2'($urandom); instr_rd = 4'($urandom); instr_rs1 = 4'($urandom);
    instr_rs2 = 4'($urandom); instr_cin = 1'($urandom);
    c = 0; f0_cnt = 0; got = 0;
    while (!got && c < 40) begin
      @(negedge clk);
      c++;
      if (alu_f0 == 2'b11) f0_cnt++;
      if (c == 1) begin
        check("exec_f0", alu_f0, op);
        check("exec_a", alu_a, ea);
        check("exec_b", alu_b, eb);
        check("exec_cin", alu_cin, (op == 2'b00) ? cn : 1'b0);
        check("exec_bin", alu_bin, (op == 2'b01) ? cn : 1'b0);
      end
      if (done) begin
        got = 1;
        instr_valid = 1'b0;
        dbg_addr = rd;
        check("done_cycle", c, ecyc);
        check("done_rd", done_rd, rd);
        check("exc", exc, (eec != 2'b00));
        check("exc_code", exc_code, eec);
      end else begin
        check("busy_ready", {busy, instr_ready}, 2'b10);
      end
    end
    if (!got) begin
      instr_valid = 1'b0;
      check("done_timeout", 0, 1);
    end
    if (op == 2'b11) check("div_f0_cycles", f0_cnt, (eb == 0) ? 1 : DIV_LAT);
    if (rd != 0) m[rd] = eres;
    @(negedge clk);
    check("done_one_pulse", done, 0);
    check("ready_after_wb", instr_ready, 1);
    check("writeback", dbg_data, m[rd]);
  endtask

  task automatic load_const(input logic [3:0] rd, input logic [15:0] v);
    run_instr(2'b00, rd, 4'd0, 4'd0, v[15], 0);
    for (int i = 14; i >= 0; i--) run_instr(2'b00, rd, rd, rd, v[i], 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    reset_model();
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_exc", {exc, exc_code}, 0);
    check("rst_done_rd", done_rd, 0);
    check("rst_alu", alu_a | alu_b | {14'd0, alu_f0} | {15'd0, alu_cin | alu_bin}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", instr_ready, 1);
    check("rst_busy_rel", busy, 0);
    sweep_regs("rst");

    // Carry out of add, then a plain add.
    load_const(4'd1, 16'hFFFF);
    load_const(4'd2, 16'h0001);
    run_instr(2'b00, 4'd3, 4'd1, 4'd2, 1'b0, 0);
    check("add_carry_r3", m[3], 16'h0000);
    load_const(4'd5, 16'h0010);
    load_const(4'd6, 16'h0020);
    run_instr(2'b00, 4'd7, 4'd5, 4'd6, 1'b0, 0);
    check("add_plain_r7", dbg_data, 16'h0030);

    // Borrow out of sub; truncating multiply.
    load_const(4'd8, 16'h0005);
    load_const(4'd9, 16'h0007);
    run_instr(2'b01, 4'd4, 4'd8, 4'd9, 1'b0, 0);
    check("sub_borrow_r4", dbg_data, 16'hFFFE);
    load_const(4'd10, 16'h0100);
    run_instr(2'b10, 4'd11, 4'd10, 4'd10, 1'b0, 0);
    check("mul_trunc_r11", dbg_data, 16'h0000);

    // Multi-cycle divide and divide by r0.
    load_const(4'd12, 16'd100);
    load_const(4'd13, 16'd7);
    run_instr(2'b11, 4'd14, 4'd12, 4'd13, 1'b0, 0);
    check("div_r14", dbg_data, 16'd14);
    run_instr(2'b11, 4'd15, 4'd12, 4'd0, 1'b0, 0);
    check("div0_r15", dbg_data, 16'hFFFF);

    // Write to r0 is discarded.
    run_instr(2'b00, 4'd0, 4'd5, 4'd6, 1'b1, 0);
    check("r0_zero", dbg_data, 16'h0000);

    // Random instructions against the model.
    for (int k = 0; k < 40; k++)
      run_instr(2'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 0);
    sweep_regs("rand");

    // Reset in the middle of a divide's EXEC window.
    @(negedge clk);
    instr_op = 2'b11; instr_rd = 4'd14; instr_rs1 = 4'd12; instr_rs2 = 4'd13; instr_cin = 1'b0;
    m[13] = 16'd0;
    instr_rs2 = 4'd13;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_alu_f0", alu_f0, 0);
    reset_model();
    dbg_addr = 4'd14;
    #1;
    check("abort_rd_cleared", dbg_data, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    run_instr(2'b00, 4'd2, 4'd0, 4'd0, 1'b1, 1);
    sweep_regs("post_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
